// File: rtl/mem_bist_ctrl.sv
// Memory built-in self-test sequencer: writes a pattern to every word, reads it back
// through the memory's registered read port and reports pass/fail and the first failing address.
module mem_bist_ctrl #(
    parameter int WIDTH_ADDR = 5,
    parameter int WIDTH_DATA = 8,
    parameter int ERR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_data_in,
    input  logic [WIDTH_DATA-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [WIDTH_ADDR-1:0] first_err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic [1:0]            mode_q;
    logic                  cmp_valid;
    logic [WIDTH_ADDR-1:0] cmp_addr;
    logic [WIDTH_DATA-1:0] cmp_exp;
    logic                  mismatch;
    logic [WIDTH_ADDR-1:0] addr_next;
    logic                  addr_last;
    logic                  err_max;

    function automatic logic [WIDTH_DATA-1:0] pattern(input logic [1:0] m,
                                                      input logic [WIDTH_ADDR-1:0] a);
        logic [WIDTH_DATA+WIDTH_ADDR-1:0] ext;
        logic [WIDTH_DATA-1:0]            p;
        ext = {{WIDTH_DATA{1'b0}}, a};
        p   = '0;
        case (m)
            2'd0: p = '0;
            2'd1: p = ext[WIDTH_DATA-1:0];
            2'd2: p = ~ext[WIDTH_DATA-1:0];
            default: begin
                for (int i = 0; i < WIDTH_DATA; i++) begin
                    p[i] = ((i % 2) == 0) ? ~a[0] : a[0];
                end
            end
        endcase
        return p;
    endfunction

    // The compare stage lines up with read data that returns one cycle after each read strobe.
    assign mismatch  = cmp_valid && (mem_data_out != cmp_exp);
    assign addr_next = mem_addr + 1'b1;
    assign addr_last = &mem_addr;
    assign err_max   = &err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            mode_q          <= 2'd0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_data_in     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            cmp_valid       <= 1'b0;
            cmp_addr        <= '0;
            cmp_exp         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_WRITE;
                        mode_q      <= mode;
                        busy        <= 1'b1;
                        mem_write   <= 1'b1;
                        mem_addr    <= '0;
                        mem_data_in <= pattern(mode, '0);
                        pass        <= 1'b0;
                    end
                end
                S_WRITE: begin
                    mem_addr <= addr_next;
                    if (addr_last) begin
                        state       <= S_READ;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_data_in <= '0;
                    end else begin
                        mem_data_in <= pattern(mode_q, addr_next);
                    end
                end
                S_READ: begin
                    mem_addr <= addr_next;
                    if (addr_last) begin
                        state    <= S_DRAIN;
                        mem_read <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The last word's compare happens in this cycle, so fold it into pass here.
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !mismatch;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            cmp_valid <= mem_read;
            cmp_addr  <= mem_addr;
            cmp_exp   <= pattern(mode_q, mem_addr);

            if (state == S_IDLE && start) begin
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else if (mismatch) begin
                if (!err_max) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a behavioural memory with per-address read faults, a scoreboard of
// expected write words and end-of-run status, and a stuck-at-zero instance with a 3-bit error counter.
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       mem_read, mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in, mem_data_out;
    logic       busy, done, pass, first_err_valid;
    logic [5:0] err_count;
    logic [4:0] first_err_addr;

    logic       start2;
    logic       mem_read2, mem_write2;
    logic [4:0] mem_addr2;
    logic [7:0] mem_data_in2;
    logic [7:0] mem_data_out2;
    logic       busy2, done2, pass2, first_err_valid2;
    logic [2:0] err_count2;
    logic [4:0] first_err_addr2;

    logic [7:0]  mem [32];
    logic [31:0] fault;
    logic [7:0]  rdata = 8'h00;

    // {addr, data} of each expected write, and {pass, first_err_valid, first_err_addr, err_count}
    logic [12:0] exp_wr_q[$];
    logic [12:0] exp_q[$];
    logic [9:0]  exp2_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int run_cyc, wr_cnt, rd_cnt;
    bit running, busy_prev;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.WIDTH_ADDR(5), .WIDTH_DATA(8), .ERR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr)
    );

    mem_bist_ctrl #(.WIDTH_ADDR(5), .WIDTH_DATA(8), .ERR_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(2'd2),
        .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2),
        .mem_data_in(mem_data_in2), .mem_data_out(mem_data_out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_err_valid(first_err_valid2), .first_err_addr(first_err_addr2)
    );

    assign mem_data_out  = rdata;
    assign mem_data_out2 = 8'h00;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) rdata <= fault[mem_addr] ? 8'hFF : mem[mem_addr];
        else          rdata <= 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_writes(input logic [1:0] m);
        logic [7:0] d;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'd0:    d = 8'h00;
                2'd1:    d = 8'(i);
                2'd2:    d = 8'hFF ^ 8'(i);
                default: d = (i % 2 == 1) ? 8'hAA : 8'h55;
            endcase
            exp_wr_q.push_back({5'(i), d});
        end
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int which);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((which == 1 && done) || (which == 2 && done2)) break;
        end
        if (k == 200) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor for the main instance: write words, phase lengths and end-of-run status.
    initial begin
        logic [12:0] e;
        running   = 0;
        busy_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                running   = 0;
                busy_prev = 0;
            end else begin
                if (busy && !busy_prev) begin
                    running = 1;
                    run_cyc = 1;
                    wr_cnt  = 0;
                    rd_cnt  = 0;
                end else if (running) begin
                    run_cyc++;
                end
                if (running && mem_write) begin
                    wr_cnt++;
                    if (exp_wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                    else begin
                        e = exp_wr_q.pop_front();
                        check("write_addr", 32'(mem_addr), 32'(e[12:8]));
                        check("write_data", 32'(mem_data_in), 32'(e[7:0]));
                    end
                end
                if (running && mem_read) rd_cnt++;
                if (done) begin
                    check("done_cycle", run_cyc, 32'd66);
                    check("write_cycles", wr_cnt, 32'd32);
                    check("read_cycles", rd_cnt, 32'd32);
                    check("busy_at_done", 32'(busy), 32'd0);
                    if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("pass", 32'(pass), 32'(e[12]));
                        check("first_err_valid", 32'(first_err_valid), 32'(e[11]));
                        check("first_err_addr", 32'(first_err_addr), 32'(e[10:6]));
                        check("err_count", 32'(err_count), 32'(e[5:0]));
                    end
                    running = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // Monitor for the saturating-counter instance.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done2) begin
                if (exp2_q.size() == 0) check("unexpected_done2", 32'd1, 32'd0);
                else begin
                    e = exp2_q.pop_front();
                    check("pass2", 32'(pass2), 32'(e[9]));
                    check("first_err_valid2", 32'(first_err_valid2), 32'(e[8]));
                    check("first_err_addr2", 32'(first_err_addr2), 32'(e[7:3]));
                    check("err_count2", 32'(err_count2), 32'(e[2:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        fault  = '0;

        // Asynchronous reset mid-cycle
        #13 rst = 1'b1;
        #1;
        check("rst_strobes", {mem_read, mem_write, busy, done, pass, first_err_valid}, 32'd0);
        check("rst_addr_data", {mem_addr, mem_data_in}, 32'd0);
        check("rst_err", {err_count, first_err_addr}, 32'd0);
        check("rst_dut2", {mem_read2, mem_write2, busy2, done2, pass2, err_count2}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // mode 0, fault-free
        push_writes(2'd0);
        exp_q.push_back({1'b1, 1'b0, 5'd0, 6'd0});
        pulse_start(2'd0);
        wait_done(1);

        // mode 3 checkerboard, fault-free
        push_writes(2'd3);
        exp_q.push_back({1'b1, 1'b0, 5'd0, 6'd0});
        pulse_start(2'd3);
        wait_done(1);

        // mode 1 with read faults at 5 and 9
        fault = (32'd1 << 5) | (32'd1 << 9);
        push_writes(2'd1);
        exp_q.push_back({1'b0, 1'b1, 5'd5, 6'd2});
        pulse_start(2'd1);
        wait_done(1);

        // fault only on the last address, seen in the drain cycle
        fault = 32'd1 << 31;
        push_writes(2'd1);
        exp_q.push_back({1'b0, 1'b1, 5'd31, 6'd1});
        pulse_start(2'd1);
        wait_done(1);
        fault = '0;

        // stuck-at-zero memory, 3-bit saturating counter
        exp2_q.push_back({1'b0, 1'b1, 5'd0, 3'd7});
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(2);

        // start held high: back-to-back runs, changes during busy ignored
        push_writes(2'd0);
        push_writes(2'd0);
        exp_q.push_back({1'b1, 1'b0, 5'd0, 6'd0});
        exp_q.push_back({1'b1, 1'b0, 5'd0, 6'd0});
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd0;
        wait_done(1);
        @(negedge clk);
        check("idle_gap_busy", {busy, done}, 32'd0);
        @(negedge clk);
        check("rerun_busy", 32'(busy), 32'd1);
        check("rerun_first_write", {mem_write, mem_addr}, {26'd0, 1'b1, 5'd0});
        mode = 2'd3;
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1);

        // reset in the READ phase abandons the run
        push_writes(2'd2);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("cycle40_reading", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_read", 32'(mem_read), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_err", {first_err_valid, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        push_writes(2'd2);
        exp_q.push_back({1'b1, 1'b0, 5'd0, 6'd0});
        pulse_start(2'd2);
        wait_done(1);

        repeat (4) @(negedge clk);
        check("status_hold_pass", 32'(pass), 32'd1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("exp2_q_empty", 32'(exp2_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Self-test sequencer that sits directly upstream of the synchronous single-port memory and drives its read/write/addr/data_in port.
- Writes a selected pattern to every address, reads every address back through the memory's 1-cycle registered read path, and compares each returned word against the expected value.
- Reports pass/fail, a saturating error count and the first failing address to the system or testbench.

Parameters:
- WIDTH_ADDR, 5, memory address width; DEPTH = 2**WIDTH_ADDR words.
- WIDTH_DATA, 8, memory word width.
- ERR_WIDTH, 6, width of err_count; the counter saturates at 2**ERR_WIDTH-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a test run; sampled only in IDLE.
- mode  in  2  pattern select, captured when start is accepted.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  WIDTH_ADDR  memory address.
- mem_data_in  out  WIDTH_DATA  write data to memory.
- mem_data_out  in  WIDTH_DATA  registered read data from memory; reads 0 in any cycle not preceded by a read.
- busy  out  1  high from the cycle after start acceptance through DRAIN.
- done  out  1  one-cycle completion pulse.
- pass  out  1  1 when the last completed run had zero mismatches.
- err_count  out  ERR_WIDTH  mismatches in the current or last run (saturating).
- first_err_valid  out  1  at least one mismatch has been seen in the current or last run.
- first_err_addr  out  WIDTH_ADDR  address of the first mismatch.

Behaviour:
- Reset (async, immediate): state=IDLE. mem_read, mem_write, mem_addr, mem_data_in, busy, done, pass, err_count, first_err_valid and first_err_addr all = 0.
- All outputs are registered.
- Pattern P(a) for address a:
  - mode 0: all zeros.
  - mode 1: a, zero-extended or truncated to WIDTH_DATA.
  - mode 2: bitwise inverse of mode 1.
  - mode 3: checkerboard, bit i = ~(i[0]^a[0]), i.e. 0x55 at even and 0xAA at odd addresses for width 8.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start=1 at an edge → WRITE.
  - At that edge: capture mode, set addr=0, clear err_count, first_err_valid, first_err_addr and pass.
- WRITE:
  - mem_write=1, mem_read=0, mem_addr=a, mem_data_in=P(a).
  - Address increments each cycle; after a=DEPTH-1 → READ with addr=0.
  - Exactly DEPTH write cycles.
- READ:
  - mem_read=1, mem_write=0, mem_addr=a, for a=0..DEPTH-1 (DEPTH cycles), then → DRAIN.
  - A compare pipeline register holds (valid, a, P(a)) for each read issued.
  - In the following cycle mem_data_out is compared against that expected value.
- DRAIN:
  - mem_read=0, mem_write=0; one cycle in which the final compare (address DEPTH-1) occurs.
  - Then → DONE.
- DONE:
  - done=1 and busy=0 for one cycle.
  - pass = (err_count==0 and no mismatch occurred in DRAIN).
  - Then → IDLE unconditionally; start is ignored in DONE.
- Compare rule: evaluated only when the pipeline valid bit is 1. A 0 returned outside a read is never compared.
- On mismatch:
  - err_count increments, saturating.
  - If first_err_valid=0: set first_err_valid=1 and capture first_err_addr.
- Latency: with start accepted at edge E0, write cycles are 1..DEPTH, read cycles DEPTH+1..2·DEPTH, DRAIN is 2·DEPTH+1, done is high in cycle 2·DEPTH+2. For DEPTH=32, done is high in cycle 66.
- During a run, mode and start changes are ignored.
- Status outputs hold their values from DONE until the next accepted start.
- Address counter wraps naturally at DEPTH-1; there is no extra cycle between the WRITE and READ phases.
- rst mid-run: the run is abandoned, strobes drop immediately, results are cleared, and the next start performs a full run.

Test Plan:
- Reset: assert rst mid-cycle, no clock → every output 0 immediately; busy=0, done=0.
- mode 0 against a fault-free memory: start for one cycle.
  - Required: 32 write cycles with mem_data_in=0x00 at addr 0..31, then 32 read cycles.
  - done pulses exactly at cycle 66; pass=1, err_count=0, first_err_valid=0.
- mode 3: monitor the writes.
  - Required: addr0=0x55, addr1=0xAA, addr30=0x55, addr31=0xAA.
  - Fault-free run → pass=1.
- mode 1 with the bench forcing mem_data_out=0xFF in the cycle after the reads of addr 5 and addr 9.
  - Required: err_count=2, first_err_valid=1, first_err_addr=5, pass=0 at done.
  - A fault on addr 31 alone is caught in DRAIN → err_count=1, first_err_addr=31.
- ERR_WIDTH=3 with mem_data_out stuck at 0x00 in mode 2 → err_count saturates at 7, first_err_addr=0, pass=0.
- start held high continuously:
  - Second run begins at the edge after DONE (the IDLE cycle); pulses during busy have no effect.
  - rst at cycle 40 (READ phase) → mem_read=0 and busy=0 at once; the following start completes a full 66-cycle run.
